hamming_tx_scheduler: RTL and testbench

Transmit-side controller for the serial Hamming encoder. It arbitrates round-robin between two 32-bit word sources and serializes the granted word MSB-first into the encoder's bit-serial input. At the start of every frame of FRAME_WORDS payload words it inserts a SYNC_WORD header, which the downstream frame synchronizer locks onto. It sits between the word producers and the encoder's data_in / data_valid / data_in_ready interface, in the encoder's input clock domain.

---
 rtl/hamming_tx_scheduler.sv | 79 +++++++
 tb/tb_hamming_tx_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hamming_tx_scheduler.sv
// hamming_tx_scheduler: round-robin word arbiter that serializes frames (sync header + payload) into a bit-serial encoder
module hamming_tx_scheduler #(
  parameter int WORD_W = 32,
  parameter int FRAME_WORDS = 8,
  parameter logic [WORD_W-1:0] SYNC_WORD = 32'h1ACFFC1D
) (
  input  logic                               clk_in,
  input  logic                               rst,
  input  logic [WORD_W-1:0]                  req0_data,
  input  logic                               req0_valid,
  output logic                               req0_ready,
  input  logic [WORD_W-1:0]                  req1_data,
  input  logic                               req1_valid,
  output logic                               req1_ready,
  output logic                               enc_data_in,
  output logic                               enc_data_valid,
  input  logic                               enc_data_in_ready,
  output logic                               frame_start,
  output logic                               busy,
  output logic                               grant_id,
  output logic [$clog2(FRAME_WORDS):0]       word_cnt
);
  localparam int CW = $clog2(FRAME_WORDS) + 1;
  localparam int BW = $clog2(WORD_W + 1);
  typedef enum logic [1:0] {IDLE, SEND_SYNC, SEND_DATA} state_t;
  state_t state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d, wc_inc, wc_eff;
  logic last_grant_q, last_grant_d, grant_id_q, grant_id_d, frame_start_q, frame_start_d;
  logic sending, last_bit, dec, any_v, sync_sel, gnt, take;
  always_comb begin
    sending = state_q != IDLE;
    last_bit = sending && bit_cnt_q == '0 && enc_data_in_ready;
    dec = !sending || last_bit;
    any_v = req0_valid || req1_valid;
    wc_inc = word_cnt_q + 1'b1;
    // a completed frame wraps the count this cycle so the same decision picks sync
    wc_eff = (state_q == SEND_DATA && last_bit) ? ((wc_inc == CW'(FRAME_WORDS)) ? '0 : wc_inc) : word_cnt_q;
    sync_sel = any_v && wc_eff == '0 && state_q != SEND_SYNC;
    gnt = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
    take = dec && any_v && !sync_sel;
    req0_ready = take && !gnt;
    req1_ready = take && gnt;
    state_d = dec ? (!any_v ? IDLE : sync_sel ? SEND_SYNC : SEND_DATA) : state_q;
    shreg_d = dec ? (!any_v ? '0 : sync_sel ? SYNC_WORD : gnt ? req1_data : req0_data)
                  : enc_data_in_ready ? shreg_q << 1 : shreg_q;
    bit_cnt_d = dec ? (any_v ? BW'(WORD_W - 1) : '0) : enc_data_in_ready ? bit_cnt_q - 1'b1 : bit_cnt_q;
    word_cnt_d = wc_eff;
    frame_start_d = dec && sync_sel;
    last_grant_d = take ? gnt : last_grant_q;
    grant_id_d = take ? gnt : grant_id_q;
  end
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_cnt_q <= '0;
      word_cnt_q <= '0;
      last_grant_q <= 1'b1;
      grant_id_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q <= grant_id_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign enc_data_in = shreg_q[WORD_W-1];
  assign enc_data_valid = state_q != IDLE;
  assign busy = state_q != IDLE;
  assign frame_start = frame_start_q;
  assign grant_id = grant_id_q;
  assign word_cnt = word_cnt_q;
endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// tb_hamming_tx_scheduler: directed bench for the round-robin frame serializer
module tb_hamming_tx_scheduler;
  localparam logic [31:0] SYNC = 32'h1ACFFC1D;
  logic clk_in = 0, rst = 1;
  logic [31:0] req0_data = 0, req1_data = 0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic enc_data_in, enc_data_valid, enc_data_in_ready = 1, frame_start, busy, grant_id;
  logic [3:0] word_cnt;
  hamming_tx_scheduler dut (
    .clk_in(clk_in), .rst(rst),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .enc_data_in(enc_data_in), .enc_data_valid(enc_data_valid), .enc_data_in_ready(enc_data_in_ready),
    .frame_start(frame_start), .busy(busy), .grant_id(grant_id), .word_cnt(word_cnt)
  );
  always #5 clk_in = ~clk_in;
  typedef struct { logic v0; logic v1; logic [31:0] d0; logic [31:0] d1; logic exp_g; int exp_wait; } vec_t;
  vec_t vt[26];
  int pass_n = 0, tot_n = 0, cyc = 0, fs_cnt = 0, m_wc = 0, m_fs = 0, run = 0, last_run = 0, nb = 0;
  int fs_cyc[$];
  logic [31:0] got_q[$], exp_q[$], sh = 0;
  always @(posedge clk_in) cyc <= cyc + 1;
  always @(negedge clk_in) begin
    if (!rst) nb <= 0;
    else if (enc_data_valid && enc_data_in_ready) begin
      sh <= {sh[30:0], enc_data_in};
      if (nb == 31) got_q.push_back({sh[30:0], enc_data_in});
      nb <= (nb == 31) ? 0 : nb + 1;
    end
    if (enc_data_valid) run <= run + 1;
    else if (run != 0) begin last_run <= run; run <= 0; end
    if (frame_start) begin fs_cnt <= fs_cnt + 1; fs_cyc.push_back(cyc); end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_n++;
  endtask
  task automatic push_exp(input logic [31:0] d);
    if (m_wc == 0) begin exp_q.push_back(SYNC); m_fs++; end
    exp_q.push_back(d);
    m_wc = (m_wc + 1) % 8;
  endtask
  task automatic xfer(input logic v0, input logic v1, input logic [31:0] d0, input logic [31:0] d1,
                      output logic g0, output logic g1, output int w);
    req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
    #1;
    w = 0;
    while (!(req0_ready || req1_ready) && w < 400) begin @(posedge clk_in); #1; w++; end
    if (w >= 400) chk("xfer_timeout", 1, 0);
    g0 = req0_ready; g1 = req1_ready;
    @(posedge clk_in); #1;
    req0_valid = 0; req1_valid = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin @(posedge clk_in); #1; n++; end
    if (n >= 2000) chk("idle_timeout", 1, 0);
  endtask
  task automatic settle();
    repeat (2) @(posedge clk_in);
    #1;
  endtask
  task automatic do_reset();
    rst = 0;
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1;
    m_wc = 0;
  endtask
  initial begin
    logic g0, g1, bad;
    int w, s, c0, f, f0, lowc;
    logic [31:0] wd;
    for (int i = 0; i < 26; i++) begin
      vt[i].v0 = i < 16;
      vt[i].v1 = 1'b1;
      vt[i].d0 = 32'hC0DE0000 | i;
      vt[i].d1 = 32'h5EED0000 | i;
      vt[i].exp_g = (i < 16) ? i[0] : 1'b1;
      vt[i].exp_wait = (i == 0) ? 32 : (i % 8 == 0) ? 63 : 31;
    end
    #2 rst = 0;
    @(posedge clk_in); #1;
    chk("rst_data_in", enc_data_in, 0);
    chk("rst_valid", enc_data_valid, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    rst = 1;
    @(posedge clk_in); #1;
    c0 = cyc;
    xfer(1, 0, 32'h5A5A0001, 0, g0, g1, w);
    push_exp(32'h5A5A0001);
    chk("t1_wait", w, 32);
    chk("t1_grant", {g0, g1}, 2'b10);
    wait_idle();
    settle();
    chk("t1_fs_latency", fs_cyc.size() > 0 ? fs_cyc[0] : -1, c0 + 1);
    chk("t1_run", last_run, 64);
    chk("t1_word_cnt", word_cnt, 1);
    chk("t1_grant_id", grant_id, 0);
    wd = 32'hF00DBEEF;
    xfer(1, 0, wd, 0, g0, g1, w);
    push_exp(wd);
    s = cyc;
    chk("t3_wait", w, 0);
    chk("t3_bit0", enc_data_in, wd[31]);
    repeat (10) @(posedge clk_in);
    #1;
    chk("t3_bit10", enc_data_in, wd[21]);
    enc_data_in_ready = 0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (enc_data_in !== wd[21] || enc_data_valid !== 1'b1) bad = 1;
      @(posedge clk_in); #1;
    end
    chk("t3_freeze", bad, 0);
    enc_data_in_ready = 1;
    wait_idle();
    chk("t3_duration", cyc - s, 37);
    chk("t3_word_cnt", word_cnt, 2);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      xfer(1, 0, 32'h11110000 + k, 0, g0, g1, w);
      push_exp(32'h11110000 + k);
      if (k == 0) chk("t4_first_wait", w, 32);
    end
    wait_idle();
    chk("t4_word_cnt3", word_cnt, 3);
    lowc = 0;
    repeat (20) begin @(posedge clk_in); #1; if (!enc_data_valid) lowc++; end
    chk("t4_gap_low", lowc, 20);
    f = fs_cnt;
    xfer(1, 0, 32'h22224444, 0, g0, g1, w);
    push_exp(32'h22224444);
    chk("t4_resume_wait", w, 0);
    wait_idle();
    settle();
    chk("t4_word_cnt4", word_cnt, 4);
    chk("t4_no_sync", fs_cnt, f);
    wd = 32'h9C3A65F0;
    xfer(0, 1, 0, wd, g0, g1, w);
    chk("t5_grant", {g0, g1}, 2'b01);
    repeat (15) @(posedge clk_in);
    #1;
    chk("t5_bit15", enc_data_in, wd[16]);
    rst = 0;
    #1;
    chk("t5_rst_out", {enc_data_in, enc_data_valid, busy, frame_start, grant_id}, 0);
    chk("t5_rst_word_cnt", word_cnt, 0);
    @(posedge clk_in); #1;
    rst = 1;
    m_wc = 0;
    f = fs_cnt;
    xfer(1, 0, 32'h0BADF00D, 0, g0, g1, w);
    push_exp(32'h0BADF00D);
    chk("t5_resync_wait", w, 32);
    wait_idle();
    settle();
    chk("t5_resync_fs", fs_cnt, f + 1);
    do_reset();
    f0 = fs_cyc.size();
    for (int i = 0; i < 26; i++) begin
      xfer(vt[i].v0, vt[i].v1, vt[i].d0, vt[i].d1, g0, g1, w);
      chk($sformatf("rr_grant%0d", i), {g0, g1}, {~vt[i].exp_g, vt[i].exp_g});
      chk($sformatf("rr_grant_id%0d", i), grant_id, vt[i].exp_g);
      chk($sformatf("rr_wait%0d", i), w, vt[i].exp_wait);
      push_exp(vt[i].exp_g ? vt[i].d1 : vt[i].d0);
    end
    wait_idle();
    settle();
    chk("rr_run", last_run, 960);
    chk("rr_frames", fs_cyc.size() - f0, 4);
    for (int k = f0 + 1; k < fs_cyc.size(); k++) chk($sformatf("rr_frame_gap%0d", k - f0), fs_cyc[k] - fs_cyc[k-1], 288);
    chk("fs_total", fs_cnt, m_fs);
    chk("words_n", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk($sformatf("word%0d", i), got_q[i], exp_q[i]);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
